// File: rtl/cva6_axi_quiesce_ctrl.sv
// AXI quiesce controller: gates AW/AR/W handshakes on the core-side master
// port and drains outstanding transactions before acknowledging isolation.
module cva6_axi_quiesce_ctrl #(
  parameter int unsigned MaxTxns = 8,
  parameter int unsigned CntW    = $clog2(MaxTxns + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            isolate_req_i,
  output logic            isolate_ack_o,
  input  logic            slv_aw_valid_i,
  output logic            slv_aw_ready_o,
  output logic            mst_aw_valid_o,
  input  logic            mst_aw_ready_i,
  input  logic            slv_ar_valid_i,
  output logic            slv_ar_ready_o,
  output logic            mst_ar_valid_o,
  input  logic            mst_ar_ready_i,
  input  logic            slv_w_valid_i,
  output logic            slv_w_ready_o,
  output logic            mst_w_valid_o,
  input  logic            mst_w_ready_i,
  input  logic            w_last_i,
  input  logic            b_fire_i,
  input  logic            r_last_fire_i,
  output logic [CntW-1:0] wr_cnt_o,
  output logic [CntW-1:0] rd_cnt_o
);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    ISO
  } state_e;

  state_e state_q, state_d;

  logic [CntW-1:0] wr_cnt_q, rd_cnt_q, wpend_q;
  logic aw_pass, ar_pass, w_pass;
  logic aw_fire, ar_fire, w_last_fire;
  logic drained;

  assign aw_pass = (state_q == RUN) && (wr_cnt_q < CntW'(MaxTxns));
  assign ar_pass = (state_q == RUN) && (rd_cnt_q < CntW'(MaxTxns));
  assign w_pass  = (wpend_q != '0);

  assign mst_aw_valid_o = aw_pass & slv_aw_valid_i;
  assign slv_aw_ready_o = aw_pass & mst_aw_ready_i;
  assign mst_ar_valid_o = ar_pass & slv_ar_valid_i;
  assign slv_ar_ready_o = ar_pass & mst_ar_ready_i;
  assign mst_w_valid_o  = w_pass & slv_w_valid_i;
  assign slv_w_ready_o  = w_pass & mst_w_ready_i;

  assign aw_fire     = mst_aw_valid_o & mst_aw_ready_i;
  assign ar_fire     = mst_ar_valid_o & mst_ar_ready_i;
  assign w_last_fire = mst_w_valid_o & mst_w_ready_i & w_last_i;

  assign drained = (wr_cnt_q == '0) && (rd_cnt_q == '0) && (wpend_q == '0);

  // Saturating up/down counter; simultaneous inc and dec cancel.
  function automatic logic [CntW-1:0] cnt_upd(
    input logic [CntW-1:0] cnt,
    input logic            inc,
    input logic            dec
  );
    logic [CntW-1:0] res;
    res = cnt;
    if (inc && !dec) res = cnt + 1'b1;
    else if (dec && !inc && cnt != '0) res = cnt - 1'b1;
    return res;
  endfunction

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:   if (isolate_req_i) state_d = DRAIN;
      DRAIN: begin
        if (!isolate_req_i) state_d = RUN;
        else if (drained)   state_d = ISO;
      end
      ISO:   if (!isolate_req_i) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= RUN;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      wpend_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= cnt_upd(wr_cnt_q, aw_fire, b_fire_i);
      rd_cnt_q <= cnt_upd(rd_cnt_q, ar_fire, r_last_fire_i);
      wpend_q  <= cnt_upd(wpend_q, aw_fire, w_last_fire);
    end
  end

  assign isolate_ack_o = (state_q == ISO);
  assign wr_cnt_o      = wr_cnt_q;
  assign rd_cnt_o      = rd_cnt_q;

  a_b_underflow : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    !(b_fire_i && !aw_fire && wr_cnt_q == '0));

  a_r_underflow : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    !(r_last_fire_i && !ar_fire && rd_cnt_q == '0));

endmodule

// File: tb/tb_cva6_axi_quiesce_ctrl.sv
// Bench for cva6_axi_quiesce_ctrl: expected values are queued as stimulus is
// driven and compared against the DUT once the cycle has been evaluated.
module tb_cva6_axi_quiesce_ctrl;

  localparam int MaxTxns = 8;
  localparam int CntW    = $clog2(MaxTxns + 1);

  localparam int S_WR  = 0;
  localparam int S_RD  = 1;
  localparam int S_ACK = 2;
  localparam int S_AWR = 3;
  localparam int S_ARR = 4;
  localparam int S_WRR = 5;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            isolate_req_i;
  logic            isolate_ack_o;
  logic            slv_aw_valid_i, slv_aw_ready_o;
  logic            mst_aw_valid_o, mst_aw_ready_i;
  logic            slv_ar_valid_i, slv_ar_ready_o;
  logic            mst_ar_valid_o, mst_ar_ready_i;
  logic            slv_w_valid_i, slv_w_ready_o;
  logic            mst_w_valid_o, mst_w_ready_i;
  logic            w_last_i;
  logic            b_fire_i;
  logic            r_last_fire_i;
  logic [CntW-1:0] wr_cnt_o, rd_cnt_o;

  cva6_axi_quiesce_ctrl #(
    .MaxTxns(MaxTxns)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .isolate_req_i (isolate_req_i),
    .isolate_ack_o (isolate_ack_o),
    .slv_aw_valid_i(slv_aw_valid_i),
    .slv_aw_ready_o(slv_aw_ready_o),
    .mst_aw_valid_o(mst_aw_valid_o),
    .mst_aw_ready_i(mst_aw_ready_i),
    .slv_ar_valid_i(slv_ar_valid_i),
    .slv_ar_ready_o(slv_ar_ready_o),
    .mst_ar_valid_o(mst_ar_valid_o),
    .mst_ar_ready_i(mst_ar_ready_i),
    .slv_w_valid_i (slv_w_valid_i),
    .slv_w_ready_o (slv_w_ready_o),
    .mst_w_valid_o (mst_w_valid_o),
    .mst_w_ready_i (mst_w_ready_i),
    .w_last_i      (w_last_i),
    .b_fire_i      (b_fire_i),
    .r_last_fire_i (r_last_fire_i),
    .wr_cnt_o      (wr_cnt_o),
    .rd_cnt_o      (rd_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string tag;
    int    sig;
    int    exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int obs(input int sig);
    case (sig)
      S_WR:    return int'(wr_cnt_o);
      S_RD:    return int'(rd_cnt_o);
      S_ACK:   return int'(isolate_ack_o);
      S_AWR:   return int'(slv_aw_ready_o);
      S_ARR:   return int'(slv_ar_ready_o);
      S_WRR:   return int'(slv_w_ready_o);
      default: return -1;
    endcase
  endfunction

  task automatic expect_v(input string tag, input int sig, input int exp);
    sb_t e;
    e.tag = tag;
    e.sig = sig;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_flush();
    sb_t e;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, obs(e.sig), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_in();
    isolate_req_i  = 1'b0;
    slv_aw_valid_i = 1'b0;
    slv_ar_valid_i = 1'b0;
    slv_w_valid_i  = 1'b0;
    w_last_i       = 1'b0;
    b_fire_i       = 1'b0;
    r_last_fire_i  = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    rst_ni = 1'b0;
    #2;
    rst_ni = 1'b1;
    tick();
  endtask

  initial begin
    mst_aw_ready_i = 1'b1;
    mst_ar_ready_i = 1'b1;
    mst_w_ready_i  = 1'b1;
    idle_in();
    rst_ni = 1'b0;
    #2;
    expect_v("rst_wr", S_WR, 0);
    expect_v("rst_rd", S_RD, 0);
    expect_v("rst_ack", S_ACK, 0);
    expect_v("rst_awr", S_AWR, 1);
    expect_v("rst_arr", S_ARR, 1);
    expect_v("rst_wrr", S_WRR, 0);
    sb_flush();
    rst_ni = 1'b1;
    tick();

    // Outstanding-write limit
    slv_aw_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      expect_v("lim_wr", S_WR, (i < MaxTxns) ? i : MaxTxns);
      expect_v("lim_awr", S_AWR, (i < MaxTxns) ? 1 : 0);
      sb_flush();
      tick();
    end
    b_fire_i = 1'b1;
    expect_v("lim_b_awr", S_AWR, 0);
    expect_v("lim_b_wr", S_WR, 8);
    sb_flush();
    tick();
    b_fire_i = 1'b0;
    expect_v("lim_reopen_awr", S_AWR, 1);
    expect_v("lim_reopen_wr", S_WR, 7);
    sb_flush();
    tick();
    expect_v("lim_full_wr", S_WR, 8);
    expect_v("lim_full_awr", S_AWR, 0);
    sb_flush();
    rst_ni = 1'b0;
    expect_v("midrst_wr", S_WR, 0);
    expect_v("midrst_awr", S_AWR, 1);
    sb_flush();
    do_reset();

    // Simultaneous increment and decrement
    slv_aw_valid_i = 1'b1;
    slv_ar_valid_i = 1'b1;
    repeat (4) tick();
    b_fire_i      = 1'b1;
    r_last_fire_i = 1'b1;
    expect_v("sim_pre_wr", S_WR, 4);
    expect_v("sim_pre_rd", S_RD, 4);
    expect_v("sim_awr", S_AWR, 1);
    expect_v("sim_arr", S_ARR, 1);
    sb_flush();
    tick();
    idle_in();
    expect_v("sim_wr", S_WR, 4);
    expect_v("sim_rd", S_RD, 4);
    sb_flush();
    do_reset();

    // W gating
    slv_w_valid_i = 1'b1;
    expect_v("w_noaw", S_WRR, 0);
    sb_flush();
    tick();
    slv_aw_valid_i = 1'b1;
    expect_v("w_aw_cycle", S_WRR, 0);
    sb_flush();
    tick();
    slv_aw_valid_i = 1'b0;
    for (int j = 0; j < 4; j++) begin
      w_last_i = (j == 3);
      expect_v("w_beat", S_WRR, 1);
      sb_flush();
      tick();
    end
    w_last_i = 1'b0;
    expect_v("w_after", S_WRR, 0);
    sb_flush();
    tick();
    do_reset();

    // Drain to isolation
    slv_aw_valid_i = 1'b1;
    slv_ar_valid_i = 1'b1;
    tick();
    slv_w_valid_i = 1'b1;
    w_last_i      = 1'b1;
    tick();
    slv_ar_valid_i = 1'b0;
    tick();
    slv_aw_valid_i = 1'b0;
    tick();
    slv_w_valid_i  = 1'b0;
    isolate_req_i  = 1'b1;
    slv_aw_valid_i = 1'b1;
    slv_ar_valid_i = 1'b1;
    expect_v("dr_pre_wr", S_WR, 3);
    expect_v("dr_pre_rd", S_RD, 2);
    expect_v("dr_trans_awr", S_AWR, 1);
    expect_v("dr_trans_arr", S_ARR, 1);
    sb_flush();
    tick();
    slv_w_valid_i = 1'b1;
    expect_v("dr_wr", S_WR, 4);
    expect_v("dr_rd", S_RD, 3);
    expect_v("dr_awr", S_AWR, 0);
    expect_v("dr_arr", S_ARR, 0);
    expect_v("dr_wrr", S_WRR, 1);
    sb_flush();
    tick();
    slv_w_valid_i  = 1'b0;
    slv_aw_valid_i = 1'b0;
    slv_ar_valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      b_fire_i      = 1'b1;
      r_last_fire_i = (k < 3);
      expect_v("dr_b_ack", S_ACK, 0);
      expect_v("dr_b_wr", S_WR, 4 - k);
      sb_flush();
      tick();
    end
    b_fire_i      = 1'b0;
    r_last_fire_i = 1'b0;
    expect_v("dr_zero_wr", S_WR, 0);
    expect_v("dr_zero_rd", S_RD, 0);
    expect_v("dr_zero_ack", S_ACK, 0);
    sb_flush();
    tick();
    expect_v("iso_ack", S_ACK, 1);
    expect_v("iso_awr", S_AWR, 0);
    sb_flush();
    isolate_req_i = 1'b0;
    tick();
    expect_v("iso_rel_ack", S_ACK, 0);
    expect_v("iso_rel_awr", S_AWR, 1);
    sb_flush();

    // Async reset while isolated
    isolate_req_i = 1'b1;
    tick();
    tick();
    expect_v("iso2_ack", S_ACK, 1);
    sb_flush();
    rst_ni = 1'b0;
    expect_v("isorst_ack", S_ACK, 0);
    expect_v("isorst_wr", S_WR, 0);
    expect_v("isorst_rd", S_RD, 0);
    expect_v("isorst_awr", S_AWR, 1);
    sb_flush();
    do_reset();

    // Abort drain
    slv_aw_valid_i = 1'b1;
    repeat (2) tick();
    slv_aw_valid_i = 1'b0;
    isolate_req_i  = 1'b1;
    tick();
    isolate_req_i = 1'b0;
    expect_v("ab_wr", S_WR, 2);
    expect_v("ab_awr", S_AWR, 0);
    expect_v("ab_ack", S_ACK, 0);
    sb_flush();
    tick();
    slv_aw_valid_i = 1'b1;
    expect_v("ab_run_awr", S_AWR, 1);
    expect_v("ab_run_ack", S_ACK, 0);
    sb_flush();
    tick();
    slv_aw_valid_i = 1'b0;
    expect_v("ab_wr3", S_WR, 3);
    expect_v("ab_ack2", S_ACK, 0);
    sb_flush();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cva6_axi_quiesce_ctrl.md
CVA6_AXI_QUIESCE_CTRL -- requirements
Module: cva6_axi_quiesce_ctrl

Interface
REQ-001 Parameter MaxTxns, default 8: max outstanding writes and max outstanding reads, each counted separately; legal range 1..255.
REQ-002 Parameter CntW, default $clog2(MaxTxns+1): width of all counters and count outputs.
REQ-003 clk_i  in  1  core clock; one clock domain only.
REQ-004 rst_ni  in  1  reset, asynchronous and active-low.
REQ-005 isolate_req_i  in  1  level request to quiesce the core-side AXI master port.
REQ-006 isolate_ack_o  out  1  high only while the port is isolated and fully drained.
REQ-007 slv_aw_valid_i / slv_aw_ready_o  in/out  1  AW handshake, core side.
REQ-008 mst_aw_valid_o / mst_aw_ready_i  out/in  1  AW handshake, CDC side.
REQ-009 slv_ar_valid_i / slv_ar_ready_o, mst_ar_valid_o / mst_ar_ready_i  1 each  AR handshake, same arrangement as AW.
REQ-010 slv_w_valid_i / slv_w_ready_o, mst_w_valid_o / mst_w_ready_i  1 each  W handshake, same arrangement as AW.
REQ-011 w_last_i  in  1  W last flag of the current beat.
REQ-012 b_fire_i  in  1  B handshake completed this cycle.
REQ-013 r_last_fire_i  in  1  R handshake with last flag set completed this cycle.
REQ-014 wr_cnt_o / rd_cnt_o  out  CntW  outstanding write / read transaction counts.
REQ-015 Payloads bypass this block; it gates valid/ready only.

Function
REQ-016 FSM states: RUN, DRAIN, ISO; state is registered; all gating is combinational from state and counters only.
REQ-017 AW pass condition: state==RUN and wr_cnt<MaxTxns. When it holds, mst_aw_valid_o=slv_aw_valid_i and slv_aw_ready_o=mst_aw_ready_i; otherwise both outputs are 0.
REQ-018 AR pass condition: same rule as AW, using rd_cnt.
REQ-019 W passes (valid and ready forwarded) only while wpend>0; otherwise both W outputs are 0.
- wpend = count of accepted AW whose W burst is not yet complete.
- W gating is identical in all states.
REQ-020 wr_cnt: +1 on AW fire, -1 on b_fire_i, unchanged when both occur in the same cycle.
REQ-021 rd_cnt: +1 on AR fire, -1 on r_last_fire_i, unchanged when both occur in the same cycle.
REQ-022 wpend: +1 on AW fire, -1 on a W fire with w_last_i=1, unchanged when both occur in the same cycle.
REQ-023 Counters never wrap. b_fire_i with wr_cnt==0, or r_last_fire_i with rd_cnt==0, holds the count at 0 and fires a simulation assertion.
REQ-024 RUN->DRAIN when isolate_req_i=1.
- AW/AR handshakes in the transition cycle complete and are counted.
- From the next cycle, AW/AR are blocked.
REQ-025 DRAIN->ISO when wr_cnt==0, rd_cnt==0 and wpend==0, evaluated on the current-cycle counter values.
REQ-026 DRAIN->RUN when isolate_req_i=0; this abort path takes priority over REQ-025.
REQ-027 ISO->RUN when isolate_req_i=0; AW/AR are reopened the following cycle.
REQ-028 isolate_ack_o = (state==ISO), registered; it rises one cycle after the drain condition is met and falls one cycle after isolate_req_i drops.
REQ-029 Counter latency: the value on wr_cnt_o/rd_cnt_o reflects a fire one cycle after that fire.

Reset
REQ-030 Reset values:
- state=RUN, all counters 0, isolate_ack_o=0;
- all valid/ready outputs take their combinational values for RUN with counters at 0.
REQ-031 Reset mid-transaction clears all counters without regard to in-flight AXI; the system guarantees core, CCU and CDC source reset together.

Verification
REQ-032 Limit: MaxTxns=8, AW issued every cycle, no B.
- Expect 8 AW fires, then slv_aw_ready_o=0 and wr_cnt_o=8.
- One b_fire_i makes the next AW pass.
REQ-033 Drain: 3 writes and 2 reads outstanding, raise isolate_req_i.
- No AW/AR fire from the next cycle.
- isolate_ack_o=1 exactly one cycle after the last B/R-last returns.
REQ-034 Simultaneous: AW fire and b_fire_i in the same cycle with wr_cnt=4 -> wr_cnt stays 4. Same test for AR/R-last.
REQ-035 W gating:
- W valid with no AW accepted -> slv_w_ready_o=0.
- After AW of a 4-beat burst, exactly 4 beats pass, then W is blocked.
REQ-036 Abort: drop isolate_req_i while in DRAIN with wr_cnt=2 -> RUN next cycle, AW reopens, isolate_ack_o never asserts.
REQ-037 Async reset while in ISO with pending counts -> isolate_ack_o=0, counters 0 and state RUN, all immediately without a clock edge.
